router_fsm_nch: RTL

- Parametrised next-generation packet-router control FSM that decodes a header address and sequences header, payload and parity writes into one of NUM_CH destination FIFOs.
- Sits between the router register/synchroniser blocks and the per-channel FIFOs.
- Differences from the fixed 3-channel controller:
  - channel count and address width are parameters;
  - the destination is latched, so wait and soft-reset act on that channel only;
  - packets with an illegal address are dropped;
  - a watchdog times out WAIT_TILL_EMPTY.

---
 rtl/router_fsm_nch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/router_fsm_nch.sv
// Packet-router control FSM: decodes the header address, latches a one-hot
// destination and sequences header/payload/parity writes into NUM_CH FIFOs.
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [NUM_CH-1:0] dest_sel,
  output logic              drop_pkt,
  output logic              timeout_err
);

  typedef enum logic [3:0] {
    DECODE_ADD         = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    CHECK_PARITY_ERROR = 4'd4,
    LOAD_PARITY        = 4'd5,
    FIFO_FULL_STATE    = 4'd6,
    LOAD_AFTER_FULL    = 4'd7,
    DROP_PKT           = 4'd8
  } state_t;

  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
  localparam logic [ADDR_W:0]  CH_LIMIT = (ADDR_W + 1)'(NUM_CH);

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] dest_dec, dest_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              addr_ok, sel_empty, sel_srst, fire;

  always_comb begin
    dest_dec  = {{(NUM_CH-1){1'b0}}, 1'b1} << data_in;
    addr_ok   = ({1'b0, data_in} < CH_LIMIT);
    sel_empty = |(fifo_empty & dest_sel);
    sel_srst  = |(soft_reset & dest_sel);
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      DECODE_ADD: begin
        if (pkt_valid) begin
          if (!addr_ok)                   state_nxt = DROP_PKT;
          else if (|(fifo_empty & dest_dec)) state_nxt = LOAD_FIRST_DATA;
          else                            state_nxt = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_nxt = FIFO_FULL_STATE;
        else if (!pkt_valid) state_nxt = LOAD_PARITY;
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADD;
      FIFO_FULL_STATE: if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_nxt = DECODE_ADD;
        else if (low_packet_valid) state_nxt = LOAD_PARITY;
        else                       state_nxt = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        // An empty flag on the final watchdog cycle still lets the packet through.
        if (sel_empty) begin
          state_nxt = LOAD_FIRST_DATA;
        end else if (WAIT_TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
          state_nxt = DROP_PKT;
          fire      = 1'b1;
        end
      end
      DROP_PKT: if (!pkt_valid) state_nxt = DECODE_ADD;
      default: state_nxt = DECODE_ADD;
    endcase
    if (sel_srst) begin
      state_nxt = DECODE_ADD;
      fire      = 1'b0;
    end
  end

  always_comb begin
    dest_nxt = dest_sel;
    if (state == DECODE_ADD && pkt_valid && addr_ok)
      dest_nxt = dest_dec;
    else if (state_nxt == DECODE_ADD || state_nxt == DROP_PKT)
      dest_nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= DECODE_ADD;
      dest_sel    <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      dest_sel    <= dest_nxt;
      timeout_err <= fire;
      wait_cnt    <= (state == WAIT_TILL_EMPTY && state_nxt == WAIT_TILL_EMPTY) ?
                     wait_cnt + 1'b1 : '0;
    end
  end

  assign detect_add    = (state == DECODE_ADD);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign drop_pkt      = (state == DROP_PKT);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                         (state == LOAD_AFTER_FULL);
  assign busy          = (state == LOAD_FIRST_DATA) || (state == WAIT_TILL_EMPTY) ||
                         (state == LOAD_PARITY) || (state == CHECK_PARITY_ERROR) ||
                         (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL);

endmodule
